// File: rtl/fft_out_collector.sv
// Gathers one FFT frame into a flat register bank, optionally undoing bit-reversed order.
// Fires start_spi once the frame is complete, then freezes the bus while the SPI stage shifts it out.
module fft_out_collector #(
    parameter int N           = 32,
    parameter int MSB         = 16,
    parameter int BIT_REV_IN  = 1,
    parameter int HOLD_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MSB/2-1:0] in_re,
    input  logic [MSB/2-1:0] in_im,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [N*MSB-1:0] data_bus,
    output logic             start_spi,
    output logic             busy,
    output logic             frame_err
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_FIRE    = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [N*MSB-1:0] bus_q, bus_d;
    logic             beat;

    function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] r;
        r = i;
        if (BIT_REV_IN != 0) begin
            for (int b = 0; b < IDX_W; b++) begin
                r[b] = i[IDX_W-1-b];
            end
        end
        return r;
    endfunction

    // A start-of-frame beat always lands at index 0, whatever the running index was.
    assign beat   = in_valid & ready_q;
    assign wr_idx = in_sof ? '0 : idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (beat && !in_sof && (idx_q == IDX_LAST)) state_d = S_FIRE;
            S_FIRE:    state_d = S_HOLD;
            S_HOLD:    if (cnt_q == '0) state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        bus_d = bus_q;
        err_d = 1'b0;
        cnt_d = cnt_q;
        if (beat) begin
            bus_d[int'(slot_of(wr_idx))*MSB +: MSB] = {in_im, in_re};
            idx_d = wr_idx + 1'b1;
            err_d = in_sof && (idx_q != '0);
        end
        if (state_q == S_FIRE) begin
            cnt_d = CNT_LOAD;
        end else if ((state_q == S_HOLD) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        // Ready lags the return to COLLECT by one clock, and drops right after the completing beat.
        ready_d = (state_q == S_COLLECT) && (state_d == S_COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            bus_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        start_spi = (state_q == S_FIRE);
        busy      = (state_q != S_COLLECT);
        in_ready  = ready_q;
        frame_err = err_q;
        data_bus  = bus_q;
    end

endmodule
